// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle event decoder: FSM state encoding and
// the default width of the pending-event counter.
package toggle_pkg;

  localparam int unsigned CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OVF  = 2'd2
  } state_e;

endpackage

// File: rtl/toggle_edge_sync.sv
// Input stages and level-change detector for a toggle-encoded event line.
// Build option TOGGLE_SYNC_EN: when defined, s1->s2 form a two-flop
// synchronizer so tog_in may be asynchronous (2-edge latency); when undefined,
// s2 is absent, s1 feeds s3 directly and tog_in must be synchronous to clk
// (1-edge latency).
module toggle_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic ev,
  output logic level_q
);

`ifdef TOGGLE_SYNC_EN
  logic s1_q, s2_q, s3_q;

  // Two-flop synchronizer followed by the tracked-level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tog_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign ev      = s2_q ^ s3_q;
  assign level_q = s3_q;
`else
  logic s1_q, s3_q;

  // Single capture stage followed by the tracked-level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tog_in;
      s3_q <= s1_q;
    end
  end

  assign ev      = s1_q ^ s3_q;
  assign level_q = s3_q;
`endif

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive-side decoder for toggle-encoded events: turns each level change of
// tog_in into an event, counts unaccepted events, offers them over a
// valid/ready handshake and flags overflow when the counter is full.
// Build option TOGGLE_SYNC_EN selects the synchronizing input stage
// (see toggle_edge_sync).
module toggle_event_decoder
  import toggle_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             ev_ready,
  input  logic             ovf_clr,
  output logic             ev_valid,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             level_q
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic             ev;
  logic             acc;
  logic             full;
  logic             drop;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;

  toggle_edge_sync u_edge (
    .clk     (clk),
    .rst     (rst),
    .tog_in  (tog_in),
    .ev      (ev),
    .level_q (level_q)
  );

  assign ev_valid = (pending_q != '0);
  assign acc      = ev_valid & ev_ready;
  assign full     = (pending_q == PEND_MAX);
  assign drop     = ev & ~acc & full;

  // Pending counter: saturates at max instead of wrapping; a simultaneous
  // event and acceptance cancel out.
  always_comb begin
    pending_d = pending_q;
    if (ev && !acc && !full) begin
      pending_d = pending_q + PEND_ONE;
    end else if (!ev && acc) begin
      pending_d = pending_q - PEND_ONE;
    end
  end

  // Sticky overflow flag: a drop in the same cycle as a clear keeps it set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Next-state logic; OVF is left on clear towards whichever state matches
  // the counter value after this edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ev) state_d = BUSY;
      end
      BUSY: begin
        if (drop) begin
          state_d = OVF;
        end else if ((pending_q == PEND_ONE) && acc && !ev) begin
          state_d = IDLE;
        end
      end
      OVF: begin
        if (ovf_clr && !drop) begin
          state_d = (pending_d == '0) ? IDLE : BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Self-checking bench for toggle_event_decoder. Works with or without
// TOGGLE_SYNC_EN defined.
`timescale 1ns/1ps
module tb_toggle_event_decoder;

  localparam int CNT_W = 4;
  localparam int PMAX  = (1 << CNT_W) - 1;
`ifdef TOGGLE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tog_in = 1'b0;
  logic             ev_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             ev_valid;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             level_q;

  int compared   = 0;
  int mismatched = 0;
  int holdCnt    = 0;

  typedef struct {
    int pend;
    bit ovf;
    bit lvl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  toggle_event_decoder #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
    .ev_ready (ev_ready),
    .ovf_clr  (ovf_clr),
    .ev_valid (ev_valid),
    .pending  (pending),
    .overflow (overflow),
    .level_q  (level_q)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, required);
    end
  endtask

  // Reference model: remembers the line level as sampled at each edge
  // (history cleared to 0 by reset); an event is a level change that is
  // LAT edges old. Pending/overflow follow the counting rules directly.
  int mPend;
  bit mOvf;
  bit seen[$];
  always @(posedge clk) begin : refModel
    exp_t e;
    bit evNow, accNow, dropNow;
    if (rst) begin
      mPend = 0;
      mOvf  = 1'b0;
      seen.delete();
      for (int i = 0; i <= LAT; i++) seen.push_back(1'b0);
    end else begin
      evNow   = (seen[LAT-1] != seen[LAT]);
      accNow  = (mPend != 0) && ev_ready;
      dropNow = evNow && !accNow && (mPend == PMAX);
      if (evNow && !accNow && !dropNow) mPend = mPend + 1;
      else if (!evNow && accNow) mPend = mPend - 1;
      if (dropNow) mOvf = 1'b1;
      else if (ovf_clr) mOvf = 1'b0;
      seen.push_front(tog_in);
      void'(seen.pop_back());
    end
    e.pend = mPend;
    e.ovf  = mOvf;
    e.lvl  = seen[LAT];
    sb.push_back(e);
  end

  // Monitor: after every edge the DUT presents a new state; pop the
  // matching expectation and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checkOutput("sb_has_entry", 0, 1);
      end else begin
        e = sb.pop_front();
        checkOutput("pending", int'(pending), e.pend);
        checkOutput("ev_valid", int'(ev_valid), (e.pend != 0) ? 1 : 0);
        checkOutput("overflow", int'(overflow), int'(e.ovf));
        checkOutput("level_q", int'(level_q), int'(e.lvl));
      end
    end
  end

  // Drives nCyc cycles of random inputs; probabilities in percent. The line
  // level is held at least two clocks, and reset also resets the sender.
  task automatic applyStimulus(input int nCyc, input int pTog, input int pReady,
                               input int pClr, input int pRst);
    for (int i = 0; i < nCyc; i++) begin
      @(negedge clk);
      if ($urandom_range(99) < pRst) begin
        rst     = 1'b1;
        tog_in  = 1'b0;
        holdCnt = 0;
      end else begin
        rst = 1'b0;
        if (holdCnt >= 1 && $urandom_range(99) < pTog) begin
          tog_in  = ~tog_in;
          holdCnt = 0;
        end else begin
          holdCnt++;
        end
      end
      ev_ready = ($urandom_range(99) < pReady);
      ovf_clr  = ($urandom_range(99) < pClr);
    end
  endtask

  initial begin : stimulus
    $display("[TB] start, latency %0d edge(s)", LAT);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] idle after reset");
    applyStimulus(10, 0, 50, 0, 0);
    $display("[TB] mixed traffic");
    applyStimulus(400, 40, 50, 10, 1);
    $display("[TB] fill to overflow");
    applyStimulus(80, 100, 0, 0, 0);
    $display("[TB] overflow with clears");
    applyStimulus(150, 90, 0, 30, 0);
    $display("[TB] drain");
    applyStimulus(40, 0, 100, 20, 0);
    $display("[TB] mixed traffic with resets");
    applyStimulus(400, 50, 40, 10, 3);
    $display("[TB] saturate then reset");
    applyStimulus(60, 100, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 100);
    applyStimulus(20, 60, 60, 0, 0);
    @(negedge clk);
    rst      = 1'b0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
